// File: rtl/ctrl_carga_anel.sv
// -----------------------------------------------------------------------------
// ctrl_carga_anel
//
// Upstream sequencer for a 4-bit synchronous ring/shift register. On start it
// captures a load pattern and a burst count. It then repeats load-then-shift
// bursts: one load cycle followed by N_SHIFT shift cycles. The bursts stop when
// the programmed count is reached, or continue until stop when rep = 0.
//
// Ports:
//   ck         in   clock, rising edge
//   clr        in   asynchronous active-low reset
//   start      in   begin a sequence (sampled only in IDLE)
//   stop       in   synchronous abort (sampled in LOAD/SHIFT)
//   pat[3:0]   in   load pattern, captured on start
//   rep[3:0]   in   burst count, captured on start (0 = continuous)
//   ld         out  1 = shifter loads i_out on next edge, 0 = shifter shifts
//   i_out[3:0] out  captured load pattern presented to the shifter
//   busy       out  high in LOAD and SHIFT
//   done       out  one-cycle pulse when a sequence ends (normal or aborted)
//   burst_cnt  out  bursts completed in the current/last sequence
//
// All outputs come from registers or are decoded from the state register. No
// input reaches an output combinationally.
// -----------------------------------------------------------------------------
module ctrl_carga_anel #(
    parameter int N_SHIFT = 4,   // shift cycles per burst, legal 1..15
    parameter int CW      = 4    // shift counter / burst_cnt width
) (
    input  logic          ck,
    input  logic          clr,
    input  logic          start,
    input  logic          stop,
    input  logic [3:0]    pat,
    input  logic [3:0]    rep,
    output logic          ld,
    output logic [3:0]    i_out,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] burst_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_FIM   = 2'd3
    } state_t;

    localparam logic [CW-1:0] LP_TERM = CW'(N_SHIFT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_pat;
    logic [3:0]    r_rep;
    logic [CW-1:0] r_burst_cnt;
    logic [CW-1:0] r_shift_cnt;

    logic          w_term;
    logic          w_last;
    logic [CW-1:0] w_burst_inc;
    logic          w_ld;
    logic          w_busy;
    logic          w_done;

    // The last shift cycle of a burst. A burst is the final one only when a
    // finite count was programmed and this burst reaches it.
    assign w_term      = (r_state == S_SHIFT) && (r_shift_cnt == LP_TERM);
    assign w_burst_inc = r_burst_cnt + 1'b1;
    assign w_last      = (r_rep != 4'd0) && (w_burst_inc == CW'(r_rep));

    // State register
    always_ff @(posedge ck or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                // stop is not looked at here, so start+stop still starts
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = stop ? S_FIM : S_SHIFT;
            end
            S_SHIFT: begin
                // an abort takes priority over the end of a burst
                if (stop) begin
                    w_next = S_FIM;
                end else if (w_term) begin
                    w_next = w_last ? S_FIM : S_LOAD;
                end
            end
            S_FIM: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output decode (Moore)
    always_comb begin
        w_ld   = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_ld   = 1'b1;
                w_busy = 1'b1;
            end
            S_SHIFT: begin
                w_busy = 1'b1;
            end
            S_FIM: begin
                w_done = 1'b1;
            end
            default: begin
                w_ld   = 1'b0;
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Capture registers and counters
    always_ff @(posedge ck or negedge clr) begin
        if (!clr) begin
            r_pat       <= 4'd0;
            r_rep       <= 4'd0;
            r_burst_cnt <= '0;
            r_shift_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pat       <= pat;
                        r_rep       <= rep;
                        r_burst_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    r_shift_cnt <= '0;
                end
                S_SHIFT: begin
                    r_shift_cnt <= r_shift_cnt + 1'b1;
                    // An aborted burst is not counted. The count wraps in
                    // continuous mode.
                    if (w_term && !stop) begin
                        r_burst_cnt <= w_burst_inc;
                    end
                end
                default: begin
                    r_shift_cnt <= r_shift_cnt;
                end
            endcase
        end
    end

    assign ld        = w_ld;
    assign busy      = w_busy;
    assign done      = w_done;
    assign i_out     = r_pat;
    assign burst_cnt = r_burst_cnt;

endmodule
